// File: rtl/alu_share_arb.sv
// -----------------------------------------------------------------------------
// alu_share_arb
//
// Time-shares one combinational ALU between two requesters:
//   client 0 - execute stage
//   client 1 - branch/address unit
//
// At most one client is granted per cycle. The granted client's operands and
// op code are driven onto the ALU. On the rising clock edge the ALU result is
// captured into that client's response register, which is presented through a
// valid/ready handshake from the following cycle on.
//
// Conflict resolution:
//   default                     round-robin; the client that did not win the
//                               last grant wins. After reset client 0 wins
//                               the first conflict.
//   ALU_ARB_FIXED_PRIO_EN       fixed priority; client 0 always wins.
//
// Parameters:
//   DATA_W  operand/result width (must match the ALU)
//   OP_W    ALU op-code width    (must match the ALU)
//
// Ports:
//   clk_i             clock, rising edge
//   rst_i             asynchronous reset, active high
//   cN_req_valid_i    client N request valid
//   cN_req_ready_o    client N request accepted this cycle
//   cN_src0_i         client N operand 0
//   cN_src1_i         client N operand 1
//   cN_op_i           client N ALU op code
//   cN_rsp_valid_o    client N result valid
//   cN_rsp_ready_i    client N consumes result
//   cN_rsp_data_o     client N result
//   alu_src0_o        to ALU operand 0
//   alu_src1_o        to ALU operand 1
//   alu_op_o          to ALU op code
//   alu_res_i         from ALU result (combinational)
// -----------------------------------------------------------------------------
module alu_share_arb #(
  parameter int DATA_W = 32,
  parameter int OP_W   = 5
) (
  input  logic              clk_i,
  input  logic              rst_i,

  input  logic              c0_req_valid_i,
  output logic              c0_req_ready_o,
  input  logic [DATA_W-1:0] c0_src0_i,
  input  logic [DATA_W-1:0] c0_src1_i,
  input  logic [OP_W-1:0]   c0_op_i,
  output logic              c0_rsp_valid_o,
  input  logic              c0_rsp_ready_i,
  output logic [DATA_W-1:0] c0_rsp_data_o,

  input  logic              c1_req_valid_i,
  output logic              c1_req_ready_o,
  input  logic [DATA_W-1:0] c1_src0_i,
  input  logic [DATA_W-1:0] c1_src1_i,
  input  logic [OP_W-1:0]   c1_op_i,
  output logic              c1_rsp_valid_o,
  input  logic              c1_rsp_ready_i,
  output logic [DATA_W-1:0] c1_rsp_data_o,

  output logic [DATA_W-1:0] alu_src0_o,
  output logic [DATA_W-1:0] alu_src1_o,
  output logic [OP_W-1:0]   alu_op_o,
  input  logic [DATA_W-1:0] alu_res_i
);

  // Response registers
  logic              c0_rsp_valid_q, c0_rsp_valid_d;
  logic [DATA_W-1:0] c0_rsp_data_q,  c0_rsp_data_d;
  logic              c1_rsp_valid_q, c1_rsp_valid_d;
  logic [DATA_W-1:0] c1_rsp_data_q,  c1_rsp_data_d;

  logic eligible_0;
  logic eligible_1;
  logic grant_0;
  logic grant_1;
  logic conflict_pick_1;

  // A client holding an undrained result may not issue; a drain in the same
  // cycle frees the slot, so drain + new issue is allowed back to back.
  assign eligible_0 = c0_req_valid_i && (!c0_rsp_valid_q || c0_rsp_ready_i);
  assign eligible_1 = c1_req_valid_i && (!c1_rsp_valid_q || c1_rsp_ready_i);

`ifdef ALU_ARB_FIXED_PRIO_EN
  // Client 0 always wins a conflict; no priority state is kept.
  assign conflict_pick_1 = 1'b0;
`else
  // Index of the client granted most recently. Resets to 1 so that client 0
  // wins the first conflict. Idle cycles leave it untouched.
  logic rr_last_q, rr_last_d;

  assign conflict_pick_1 = (rr_last_q == 1'b0);

  always_comb begin
    rr_last_d = rr_last_q;
    if (grant_0) begin
      rr_last_d = 1'b0;
    end else if (grant_1) begin
      rr_last_d = 1'b1;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      rr_last_q <= 1'b1;
    end else begin
      rr_last_q <= rr_last_d;
    end
  end
`endif

  // Grant is suppressed while reset is held so the ALU sees zeros and no
  // client believes its request was taken during reset.
  always_comb begin
    grant_0 = 1'b0;
    grant_1 = 1'b0;
    if (!rst_i) begin
      if (eligible_0 && eligible_1) begin
        grant_0 = !conflict_pick_1;
        grant_1 = conflict_pick_1;
      end else begin
        grant_0 = eligible_0;
        grant_1 = eligible_1;
      end
    end
  end

  assign c0_req_ready_o = grant_0;
  assign c1_req_ready_o = grant_1;

  // ALU operand mux; zeros (ADD of 0,0) when nothing is granted.
  always_comb begin
    alu_src0_o = '0;
    alu_src1_o = '0;
    alu_op_o   = '0;
    if (grant_0) begin
      alu_src0_o = c0_src0_i;
      alu_src1_o = c0_src1_i;
      alu_op_o   = c0_op_i;
    end else if (grant_1) begin
      alu_src0_o = c1_src0_i;
      alu_src1_o = c1_src1_i;
      alu_op_o   = c1_op_i;
    end
  end

  // Response next state. A new accept takes precedence over a drain, so a
  // same-cycle drain + accept keeps valid high and loads the new result.
  // Data is never cleared by a drain; it holds the last result.
  always_comb begin
    c0_rsp_valid_d = c0_rsp_valid_q;
    c0_rsp_data_d  = c0_rsp_data_q;
    if (grant_0) begin
      c0_rsp_valid_d = 1'b1;
      c0_rsp_data_d  = alu_res_i;
    end else if (c0_rsp_valid_q && c0_rsp_ready_i) begin
      c0_rsp_valid_d = 1'b0;
    end
  end

  always_comb begin
    c1_rsp_valid_d = c1_rsp_valid_q;
    c1_rsp_data_d  = c1_rsp_data_q;
    if (grant_1) begin
      c1_rsp_valid_d = 1'b1;
      c1_rsp_data_d  = alu_res_i;
    end else if (c1_rsp_valid_q && c1_rsp_ready_i) begin
      c1_rsp_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      c0_rsp_valid_q <= 1'b0;
      c0_rsp_data_q  <= '0;
      c1_rsp_valid_q <= 1'b0;
      c1_rsp_data_q  <= '0;
    end else begin
      c0_rsp_valid_q <= c0_rsp_valid_d;
      c0_rsp_data_q  <= c0_rsp_data_d;
      c1_rsp_valid_q <= c1_rsp_valid_d;
      c1_rsp_data_q  <= c1_rsp_data_d;
    end
  end

  assign c0_rsp_valid_o = c0_rsp_valid_q;
  assign c0_rsp_data_o  = c0_rsp_data_q;
  assign c1_rsp_valid_o = c1_rsp_valid_q;
  assign c1_rsp_data_o  = c1_rsp_data_q;

endmodule

// File: tb/tb_alu_share_arb.sv
// -----------------------------------------------------------------------------
// tb_alu_share_arb
//
// Scenario-driven bench for alu_share_arb. The ALU is modelled combinationally
// (ADD, SUB, AND, OR, XOR, SLTU; other codes give 0). Expected behaviour comes
// from a transaction-level reference: per client a "result pending" flag and
// the last result value, plus the index of the last winner.
// Honours ALU_ARB_FIXED_PRIO_EN the same way as the design.
// -----------------------------------------------------------------------------
module tb_alu_share_arb;

  localparam int DW = 32;
  localparam int OW = 5;

  logic          clk;
  logic          rst;
  logic          c0_req_valid, c0_req_ready, c0_rsp_valid, c0_rsp_ready;
  logic [DW-1:0] c0_src0, c0_src1, c0_rsp_data;
  logic [OW-1:0] c0_op;
  logic          c1_req_valid, c1_req_ready, c1_rsp_valid, c1_rsp_ready;
  logic [DW-1:0] c1_src0, c1_src1, c1_rsp_data;
  logic [OW-1:0] c1_op;
  logic [DW-1:0] alu_src0, alu_src1, alu_res;
  logic [OW-1:0] alu_op;

  int errors = 0;
  int checks = 0;

  alu_share_arb #(.DATA_W(DW), .OP_W(OW)) dut (
    .clk_i(clk), .rst_i(rst),
    .c0_req_valid_i(c0_req_valid), .c0_req_ready_o(c0_req_ready),
    .c0_src0_i(c0_src0), .c0_src1_i(c0_src1), .c0_op_i(c0_op),
    .c0_rsp_valid_o(c0_rsp_valid), .c0_rsp_ready_i(c0_rsp_ready),
    .c0_rsp_data_o(c0_rsp_data),
    .c1_req_valid_i(c1_req_valid), .c1_req_ready_o(c1_req_ready),
    .c1_src0_i(c1_src0), .c1_src1_i(c1_src1), .c1_op_i(c1_op),
    .c1_rsp_valid_o(c1_rsp_valid), .c1_rsp_ready_i(c1_rsp_ready),
    .c1_rsp_data_o(c1_rsp_data),
    .alu_src0_o(alu_src0), .alu_src1_o(alu_src1), .alu_op_o(alu_op),
    .alu_res_i(alu_res)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [DW-1:0] alu_f(logic [DW-1:0] a, logic [DW-1:0] b, logic [OW-1:0] op);
    case (op)
      5'd0:    return a + b;
      5'd1:    return a - b;
      5'd2:    return a & b;
      5'd3:    return a | b;
      5'd4:    return a ^ b;
      5'd5:    return (a < b) ? 32'd1 : 32'd0;
      default: return '0;
    endcase
  endfunction

  assign alu_res = alu_f(alu_src0, alu_src1, alu_op);

  // Reference model state
  logic          m_vld [2];
  logic [DW-1:0] m_dat [2];
  int            m_last;
  int            m_gnt;
  logic [DW-1:0] m_s0, m_s1;
  logic [OW-1:0] m_op;

  task automatic model_reset();
    m_vld[0] = 1'b0; m_vld[1] = 1'b0;
    m_dat[0] = '0;   m_dat[1] = '0;
    m_last   = 1;
  endtask

  // Who should win this cycle, from the current inputs and pending results.
  task automatic model_eval();
    bit want0, want1;
    want0 = c0_req_valid && (!m_vld[0] || c0_rsp_ready);
    want1 = c1_req_valid && (!m_vld[1] || c1_rsp_ready);
    if (rst)                m_gnt = -1;
`ifdef ALU_ARB_FIXED_PRIO_EN
    else if (want0 && want1) m_gnt = 0;
`else
    else if (want0 && want1) m_gnt = 1 - m_last;
`endif
    else if (want0)          m_gnt = 0;
    else if (want1)          m_gnt = 1;
    else                     m_gnt = -1;
    m_s0 = (m_gnt == 0) ? c0_src0 : (m_gnt == 1) ? c1_src0 : '0;
    m_s1 = (m_gnt == 0) ? c0_src1 : (m_gnt == 1) ? c1_src1 : '0;
    m_op = (m_gnt == 0) ? c0_op   : (m_gnt == 1) ? c1_op   : '0;
  endtask

  task automatic settle();
    model_eval();
    #1;
  endtask

  // Advance one clock; inputs are held from the preceding negedge.
  task automatic tick();
    logic [DW-1:0] r;
    bit rd0, rd1;
    model_eval();
    r   = alu_f(m_s0, m_s1, m_op);
    rd0 = c0_rsp_ready;
    rd1 = c1_rsp_ready;
    @(posedge clk);
    if (m_gnt == 0) begin m_vld[0] = 1'b1; m_dat[0] = r; end
    else if (m_vld[0] && rd0) m_vld[0] = 1'b0;
    if (m_gnt == 1) begin m_vld[1] = 1'b1; m_dat[1] = r; end
    else if (m_vld[1] && rd1) m_vld[1] = 1'b0;
    if (m_gnt >= 0) m_last = m_gnt;
    @(negedge clk);
  endtask

  task automatic drive0(bit v, logic [DW-1:0] a, logic [DW-1:0] b, logic [OW-1:0] op, bit rr);
    c0_req_valid = v; c0_src0 = a; c0_src1 = b; c0_op = op; c0_rsp_ready = rr;
  endtask

  task automatic drive1(bit v, logic [DW-1:0] a, logic [DW-1:0] b, logic [OW-1:0] op, bit rr);
    c1_req_valid = v; c1_src0 = a; c1_src1 = b; c1_op = op; c1_rsp_ready = rr;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    model_reset();
  endtask

  // ---------------------------------------------------------------------------
  task automatic test_reset();
    drive0(1'b0, '0, '0, '0, 1'b0);
    drive1(1'b0, '0, '0, '0, 1'b0);
    rst = 1'b1;
    @(negedge clk);
    settle();
    checks++; if (c0_rsp_valid !== 1'b0) begin errors++; $display("FAIL reset_c0_rsp_valid got=%b exp=0", c0_rsp_valid); end
    checks++; if (c1_rsp_valid !== 1'b0) begin errors++; $display("FAIL reset_c1_rsp_valid got=%b exp=0", c1_rsp_valid); end
    checks++; if (c0_rsp_data !== '0) begin errors++; $display("FAIL reset_c0_rsp_data got=%h exp=0", c0_rsp_data); end
    checks++; if (c1_rsp_data !== '0) begin errors++; $display("FAIL reset_c1_rsp_data got=%h exp=0", c1_rsp_data); end
    checks++; if ({alu_op, alu_src0, alu_src1} !== '0) begin errors++; $display("FAIL reset_alu got op=%h s0=%h s1=%h exp=0", alu_op, alu_src0, alu_src1); end
    @(negedge clk);
    rst = 1'b0;
    model_reset();
  endtask

  task automatic test_single();
    drive0(1'b1, 32'd5, 32'd7, 5'd0, 1'b1);
    settle();
    checks++; if (c0_req_ready !== 1'b1) begin errors++; $display("FAIL single_req_ready got=%b exp=1", c0_req_ready); end
    checks++; if (c1_req_ready !== 1'b0) begin errors++; $display("FAIL single_c1_ready got=%b exp=0", c1_req_ready); end
    checks++; if (alu_src0 !== 32'd5 || alu_src1 !== 32'd7 || alu_op !== 5'd0) begin errors++; $display("FAIL single_alu got s0=%0d s1=%0d op=%0d exp 5 7 0", alu_src0, alu_src1, alu_op); end
    tick();
    drive0(1'b0, '0, '0, '0, 1'b1);
    settle();
    checks++; if (c0_rsp_valid !== 1'b1) begin errors++; $display("FAIL single_rsp_valid got=%b exp=1", c0_rsp_valid); end
    checks++; if (c0_rsp_data !== 32'd12) begin errors++; $display("FAIL single_rsp_data got=%0d exp=12", c0_rsp_data); end
    checks++; if (alu_op !== '0 || alu_src0 !== '0) begin errors++; $display("FAIL single_idle_alu got op=%0d s0=%0d exp 0", alu_op, alu_src0); end
    tick();
    settle();
    checks++; if (c0_rsp_valid !== 1'b0) begin errors++; $display("FAIL single_drain got=%b exp=0", c0_rsp_valid); end
    checks++; if (c0_rsp_data !== 32'd12) begin errors++; $display("FAIL single_hold_data got=%0d exp=12", c0_rsp_data); end
  endtask

  task automatic test_conflict();
    bit exp0;
    drive0(1'b0, '0, '0, '0, 1'b1);
    drive1(1'b0, '0, '0, '0, 1'b1);
    do_reset();
    drive0(1'b1, 32'd10, 32'd3, 5'd1, 1'b1);
    drive1(1'b1, 32'hF0, 32'h3C, 5'd2, 1'b1);
    settle();
    checks++; if (c0_req_ready !== 1'b1 || c1_req_ready !== 1'b0) begin errors++; $display("FAIL conflict_first got r0=%b r1=%b exp 1 0", c0_req_ready, c1_req_ready); end
    tick();
    settle();
    checks++; if (c0_rsp_data !== 32'd7 || c0_rsp_valid !== 1'b1) begin errors++; $display("FAIL conflict_c0_data got=%0d v=%b exp=7 v=1", c0_rsp_data, c0_rsp_valid); end
`ifdef ALU_ARB_FIXED_PRIO_EN
    drive0(1'b0, '0, '0, '0, 1'b1);
    settle();
`endif
    checks++; if (c1_req_ready !== 1'b1 || c0_req_ready !== 1'b0) begin errors++; $display("FAIL conflict_second got r0=%b r1=%b exp 0 1", c0_req_ready, c1_req_ready); end
    tick();
    settle();
    checks++; if (c1_rsp_data !== 32'h30 || c1_rsp_valid !== 1'b1) begin errors++; $display("FAIL conflict_c1_data got=%h v=%b exp=30 v=1", c1_rsp_data, c1_rsp_valid); end
    for (int k = 0; k < 8; k++) begin
      drive0(1'b1, $urandom, $urandom, 5'($urandom_range(0, 5)), 1'b1);
      drive1(1'b1, $urandom, $urandom, 5'($urandom_range(0, 5)), 1'b1);
      settle();
`ifdef ALU_ARB_FIXED_PRIO_EN
      exp0 = 1'b1;
`else
      exp0 = (k % 2 == 0);
`endif
      checks++; if (c0_req_ready !== exp0 || c1_req_ready !== !exp0) begin errors++; $display("FAIL conflict_alt k=%0d got r0=%b r1=%b exp r0=%b", k, c0_req_ready, c1_req_ready, exp0); end
      checks++; if (alu_src0 !== (exp0 ? c0_src0 : c1_src0)) begin errors++; $display("FAIL conflict_alu k=%0d got=%h", k, alu_src0); end
      tick();
      settle();
      checks++; if (c0_rsp_data !== m_dat[0] || c1_rsp_data !== m_dat[1]) begin errors++; $display("FAIL conflict_data k=%0d got %h %h exp %h %h", k, c0_rsp_data, c1_rsp_data, m_dat[0], m_dat[1]); end
    end
  endtask

  task automatic test_backpressure();
    drive0(1'b0, '0, '0, '0, 1'b1);
    drive1(1'b0, '0, '0, '0, 1'b1);
    do_reset();
    drive1(1'b1, 32'd1, 32'd2, 5'd5, 1'b0);
    settle();
    checks++; if (c1_req_ready !== 1'b1) begin errors++; $display("FAIL bp_first_accept got=%b exp=1", c1_req_ready); end
    tick();
    drive1(1'b1, 32'd100, 32'd200, 5'd0, 1'b0);
    for (int k = 0; k < 3; k++) begin
      drive0(1'b1, $urandom, $urandom, 5'($urandom_range(0, 5)), 1'b1);
      settle();
      checks++; if (c1_req_ready !== 1'b0) begin errors++; $display("FAIL bp_c1_blocked k=%0d got=%b exp=0", k, c1_req_ready); end
      checks++; if (c1_rsp_valid !== 1'b1 || c1_rsp_data !== 32'd1) begin errors++; $display("FAIL bp_c1_hold k=%0d got v=%b d=%0d exp v=1 d=1", k, c1_rsp_valid, c1_rsp_data); end
      checks++; if (c0_req_ready !== 1'b1) begin errors++; $display("FAIL bp_c0_served k=%0d got=%b exp=1", k, c0_req_ready); end
      tick();
      settle();
      checks++; if (c0_rsp_data !== m_dat[0]) begin errors++; $display("FAIL bp_c0_data k=%0d got=%h exp=%h", k, c0_rsp_data, m_dat[0]); end
    end
    drive0(1'b0, '0, '0, '0, 1'b1);
    c1_rsp_ready = 1'b1;
    settle();
    checks++; if (c1_req_ready !== 1'b1) begin errors++; $display("FAIL bp_release_accept got=%b exp=1", c1_req_ready); end
    tick();
    drive1(1'b0, '0, '0, '0, 1'b1);
    settle();
    checks++; if (c1_rsp_valid !== 1'b1 || c1_rsp_data !== 32'd300) begin errors++; $display("FAIL bp_no_bubble got v=%b d=%0d exp v=1 d=300", c1_rsp_valid, c1_rsp_data); end
    tick();
  endtask

  task automatic test_idle_prio();
    drive0(1'b0, '0, '0, '0, 1'b1);
    drive1(1'b1, 32'd4, 32'd4, 5'd0, 1'b1);
    tick();
    drive1(1'b0, '0, '0, '0, 1'b1);
    repeat (5) tick();
    drive0(1'b1, 32'd1, 32'd1, 5'd4, 1'b1);
    drive1(1'b1, 32'd2, 32'd2, 5'd4, 1'b1);
    settle();
    checks++; if (c0_req_ready !== 1'b1 || c1_req_ready !== 1'b0) begin errors++; $display("FAIL idle_prio got r0=%b r1=%b exp 1 0", c0_req_ready, c1_req_ready); end
    tick();
    drive0(1'b0, '0, '0, '0, 1'b1);
    drive1(1'b0, '0, '0, '0, 1'b1);
    tick();
  endtask

  task automatic test_random();
    for (int k = 0; k < 400; k++) begin
      drive0($urandom_range(0, 3) != 0, $urandom, $urandom, 5'($urandom_range(0, 7)), $urandom_range(0, 2) != 0);
      drive1($urandom_range(0, 3) != 0, $urandom, $urandom, 5'($urandom_range(0, 7)), $urandom_range(0, 2) != 0);
      settle();
      checks++; if (c0_req_ready !== (m_gnt == 0) || c1_req_ready !== (m_gnt == 1)) begin errors++; $display("FAIL rand_grant k=%0d got r0=%b r1=%b exp gnt=%0d", k, c0_req_ready, c1_req_ready, m_gnt); end
      checks++; if (alu_src0 !== m_s0 || alu_src1 !== m_s1 || alu_op !== m_op) begin errors++; $display("FAIL rand_alu k=%0d got %h %h %h exp %h %h %h", k, alu_src0, alu_src1, alu_op, m_s0, m_s1, m_op); end
      checks++; if (c0_rsp_valid !== m_vld[0] || c0_rsp_data !== m_dat[0]) begin errors++; $display("FAIL rand_c0_rsp k=%0d got v=%b d=%h exp v=%b d=%h", k, c0_rsp_valid, c0_rsp_data, m_vld[0], m_dat[0]); end
      checks++; if (c1_rsp_valid !== m_vld[1] || c1_rsp_data !== m_dat[1]) begin errors++; $display("FAIL rand_c1_rsp k=%0d got v=%b d=%h exp v=%b d=%h", k, c1_rsp_valid, c1_rsp_data, m_vld[1], m_dat[1]); end
      tick();
    end
  endtask

  task automatic test_reset_mid();
    drive0(1'b1, 32'd9, 32'd9, 5'd0, 1'b0);
    drive1(1'b0, '0, '0, '0, 1'b0);
    tick();
    tick();
    settle();
    checks++; if (c0_rsp_valid !== 1'b1) begin errors++; $display("FAIL midrst_pre_valid got=%b exp=1", c0_rsp_valid); end
    #1 rst = 1'b1;
    #1;
    checks++; if (c0_rsp_valid !== 1'b0 || c1_rsp_valid !== 1'b0) begin errors++; $display("FAIL midrst_valid got %b %b exp 0 0", c0_rsp_valid, c1_rsp_valid); end
    checks++; if (c0_rsp_data !== '0) begin errors++; $display("FAIL midrst_data got=%h exp=0", c0_rsp_data); end
    checks++; if (alu_op !== '0 || alu_src0 !== '0 || c0_req_ready !== 1'b0) begin errors++; $display("FAIL midrst_alu got op=%h s0=%h rdy=%b exp 0", alu_op, alu_src0, c0_req_ready); end
    @(negedge clk);
    rst = 1'b0;
    model_reset();
    drive0(1'b0, '0, '0, '0, 1'b1);
    tick();
  endtask

  initial begin
    rst = 1'b1;
    drive0(1'b0, '0, '0, '0, 1'b0);
    drive1(1'b0, '0, '0, '0, 1'b0);
    model_reset();
    m_gnt = -1;
    test_reset();
    test_single();
    test_conflict();
    test_backpressure();
    test_idle_prio();
    test_random();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/alu_share_arb.md
Name: alu_share_arb

Overview:
- Two-requester arbiter that time-shares the single combinational CPU ALU between client 0 (execute stage) and client 1 (branch/address unit).
- Each cycle it grants at most one client by round-robin and drives that client's operands and op code onto the ALU.
- It captures the ALU result into that client's response register, presented with a valid/ready handshake one cycle later.

Parameters:
- DATA_W, 32, operand/result width; must match the ALU.
- OP_W, 5, ALU op-code width; must match the ALU op encoding.

Ports:
- clk  in  1  clock; all state updates on rising edge
- rst  in  1  asynchronous, active-high reset
- c0_req_valid  in  1  client 0 request valid
- c0_req_ready  out  1  client 0 request accepted this cycle (when valid)
- c0_src0  in  DATA_W  client 0 operand 0
- c0_src1  in  DATA_W  client 0 operand 1
- c0_op  in  OP_W  client 0 ALU op code
- c0_rsp_valid  out  1  client 0 result valid
- c0_rsp_ready  in  1  client 0 consumes result
- c0_rsp_data  out  DATA_W  client 0 result
- c1_*  same eight signals for client 1
- alu_src0  out  DATA_W  to ALU operand 0
- alu_src1  out  DATA_W  to ALU operand 1
- alu_op  out  OP_W  to ALU op code
- alu_res  in  DATA_W  from ALU result (combinational)

Behaviour:
- Reset (async, rst=1): c0/c1_rsp_valid=0, c0/c1_rsp_data=0, rr_last=1 (client 0 wins the first conflict). alu_* outputs =0 because there is no grant.
- Eligibility: eligible_i = ci_req_valid && (!ci_rsp_valid || ci_rsp_ready). A client with an undrained result cannot issue. Same-cycle drain plus new issue is allowed.
- Grant (combinational):
  - Only one eligible client: grant it.
  - Both eligible: grant the client != rr_last.
  - Neither eligible: no grant.
- ci_req_ready = grant_i. The ready signal depends on req_valid; clients must not make req_valid depend on req_ready.
- ALU drive: the granted client's src0/src1/op go to alu_*. With no grant, alu_src0=0, alu_src1=0, alu_op=0 (ADD of zeros; keeps the ALU quiet and deterministic).
- Accept edge: on a rising clk with grant_i:
  - ci_rsp_data <= alu_res
  - ci_rsp_valid <= 1
  - rr_last <= i
- Latency: result visible the cycle after acceptance. Throughput: one op per cycle total across both clients.
- Drain: on a rising clk with ci_rsp_valid && ci_rsp_ready and no new grant_i, ci_rsp_valid <= 0. ci_rsp_data holds its last value (not cleared).
- Simultaneous drain + accept on the same client: rsp_valid stays 1 and rsp_data takes the new result; no bubble.
- rr_last updates only on an actual grant. Idle cycles do not move priority.
- Starvation: when both clients continuously request with prompt drain, grants strictly alternate 0,1,0,1...
- rsp_valid and rsp_data must stay stable while rsp_ready=0.
- Reset mid-operation: pending results are discarded and rsp_valid drops immediately (async). Any request in flight is lost; clients must reissue.
- Op codes pass through unchecked. An undefined op yields whatever the ALU yields (0 for unknown codes).

Optional Feature:
- Macro ALU_ARB_FIXED_PRIO_EN.
- Defined: fixed priority; client 0 always wins a conflict. rr_last is removed or ignored; all else is unchanged.
- Undefined: round-robin as above.

Test Plan:
- Reset: assert rst mid-cycle with c0_rsp_valid=1 -> c0/c1_rsp_valid=0 immediately, rsp_data=0, alu_op=0.
- Single client: c0 op=5'b00000 src0=5 src1=7 valid one cycle, c0_rsp_ready=1 -> c0_req_ready=1 that cycle, c0_rsp_valid=1 next cycle with data 12, then deasserts.
- Conflict after reset: c0 SUB(10,3) and c1 AND(0xF0,0x3C) both valid at once -> c0 granted first (data 7), c1 granted next cycle (data 0x30), then alternation c0,c1,c0 over 4 further back-to-back pairs.
- Backpressure: c1 SLTU(1,2) accepted, c1_rsp_ready=0 for 3 cycles while c1 requests again -> c1_req_ready=0 and c1_rsp_data stays 1. Meanwhile c0 is served every cycle. When c1_rsp_ready=1, the second c1 op is accepted in the same cycle with no bubble.
- Idle priority hold: grant c1, idle 5 cycles, both request -> c0 wins (rr_last unchanged by idle cycles).
- With ALU_ARB_FIXED_PRIO_EN defined, both clients request continuously with prompt drain -> c0 granted every cycle and c1 never granted until c0 drops valid.
